// File: rtl/output_requant_buffer_pkg.sv
// Shared types and constants for the output requantization buffer.
package output_requant_buffer_pkg;

   localparam int ACCUMULATION_WIDTH = 32;
   localparam int IO_DATA_WIDTH      = 16;
   localparam int FEATURE_MAP_WIDTH  = 1024;
   localparam int FEATURE_MAP_HEIGHT = 1024;
   localparam int OUTPUT_NB_CHANNELS = 64;
   localparam int DEFAULT_FIFO_DEPTH = 4;

   localparam int X_W  = $clog2(FEATURE_MAP_WIDTH);
   localparam int Y_W  = $clog2(FEATURE_MAP_HEIGHT);
   localparam int CH_W = $clog2(OUTPUT_NB_CHANNELS);

   localparam int SAT_MAX = 32767;
   localparam int SAT_MIN = -32768;

   typedef struct packed {
      logic [IO_DATA_WIDTH-1:0] data;
      logic [X_W-1:0]           x;
      logic [Y_W-1:0]           y;
      logic [CH_W-1:0]          ch;
      logic                     sat;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/output_requant_buffer_sync_fifo.sv
// Small synchronous FIFO with register storage; the head is read straight from
// the storage flops so it is stable while the consumer stalls.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             arst_n_in,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge arst_n_in) begin
         if (!arst_n_in) begin
            mem_q[gi] <= '0;
         end else begin
            mem_q[gi] <= mem_d[gi];
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/output_requant_buffer.sv
// Requantizes accumulator results to 16-bit saturated values and buffers them
// for a valid/ready consumer. Define REQUANT_ROUND_EN for round-half-up.
module output_requant_buffer
   import output_requant_buffer_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          arst_n_in,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ACCUMULATION_WIDTH-1:0] in_data,
   input  logic [X_W-1:0]                in_x,
   input  logic [Y_W-1:0]                in_y,
   input  logic [CH_W-1:0]               in_ch,
   input  logic [4:0]                    shift,
   input  logic                          clear,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [IO_DATA_WIDTH-1:0]      out_data,
   output logic [X_W-1:0]                out_x,
   output logic [Y_W-1:0]                out_y,
   output logic [CH_W-1:0]               out_ch,
   output logic                          out_saturated,
   output logic                          overflow,
   output logic [15:0]                   sat_count
);

   localparam int EXT_W = ACCUMULATION_WIDTH + 1;
   localparam logic signed [EXT_W-1:0] SAT_MAX_EXT = EXT_W'(SAT_MAX);
   localparam logic signed [EXT_W-1:0] SAT_MIN_EXT = EXT_W'(SAT_MIN);

   logic              full, empty, push, pop, drop;
   entry_t            wr_entry, head;
   logic signed [EXT_W-1:0] acc_ext, t_val;
   logic              overflow_q, overflow_d;
   logic [15:0]       sat_count_q, sat_count_d;

   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign in_ready  = !full || pop;
   assign push      = in_valid && in_ready;
   assign drop      = in_valid && !in_ready;

   always_comb begin
      acc_ext = {in_data[ACCUMULATION_WIDTH-1], in_data};
`ifdef REQUANT_ROUND_EN
      if (shift != 5'd0) begin
         t_val = (acc_ext + (EXT_W'(1) << (shift - 5'd1))) >>> shift;
      end else begin
         t_val = acc_ext;
      end
`else
      t_val = acc_ext >>> shift;
`endif
      wr_entry.x   = in_x;
      wr_entry.y   = in_y;
      wr_entry.ch  = in_ch;
      wr_entry.sat = 1'b0;
      wr_entry.data = t_val[IO_DATA_WIDTH-1:0];
      if (t_val > SAT_MAX_EXT) begin
         wr_entry.data = IO_DATA_WIDTH'(SAT_MAX);
         wr_entry.sat  = 1'b1;
      end else if (t_val < SAT_MIN_EXT) begin
         wr_entry.data = IO_DATA_WIDTH'(SAT_MIN);
         wr_entry.sat  = 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .push      (push),
      .pop       (pop),
      .wr_data   (wr_entry),
      .full      (full),
      .empty     (empty),
      .head      (head)
   );

   always_comb begin
      overflow_d  = overflow_q;
      sat_count_d = sat_count_q;
      if (clear) begin
         overflow_d  = 1'b0;
         sat_count_d = '0;
      end else begin
         if (drop) begin
            overflow_d = 1'b1;
         end
         if (push && wr_entry.sat && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         overflow_q  <= 1'b0;
         sat_count_q <= '0;
      end else begin
         overflow_q  <= overflow_d;
         sat_count_q <= sat_count_d;
      end
   end

   assign overflow      = overflow_q;
   assign sat_count     = sat_count_q;
   assign out_data      = head.data;
   assign out_x         = head.x;
   assign out_y         = head.y;
   assign out_ch        = head.ch;
   assign out_saturated = head.sat;

endmodule

// File: tb/tb_output_requant_buffer.sv
// Self-checking bench for output_requant_buffer: vector table, hand sequences
// and randomized traffic against a queue-based reference model.
module tb_output_requant_buffer;

   logic        clk = 1'b0;
   logic        arst_n_in;
   logic        in_valid, in_ready;
   logic [31:0] in_data;
   logic [9:0]  in_x, in_y;
   logic [5:0]  in_ch;
   logic [4:0]  shift;
   logic        clear;
   logic        out_valid, out_ready;
   logic [15:0] out_data;
   logic [9:0]  out_x, out_y;
   logic [5:0]  out_ch;
   logic        out_saturated, overflow;
   logic [15:0] sat_count;

   always #5 clk = ~clk;

   output_requant_buffer dut (
      .clk           (clk),
      .arst_n_in     (arst_n_in),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_x          (in_x),
      .in_y          (in_y),
      .in_ch         (in_ch),
      .shift         (shift),
      .clear         (clear),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_x         (out_x),
      .out_y         (out_y),
      .out_ch        (out_ch),
      .out_saturated (out_saturated),
      .overflow      (overflow),
      .sat_count     (sat_count)
   );

   typedef struct {
      logic [15:0] data;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [5:0]  ch;
      logic        sat;
   } exp_t;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  sh;
      logic [15:0] exp_data;
      logic        exp_sat;
   } vec_t;

   localparam int DEPTH = 4;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   logic ovf_m;
   int   satc_m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Exact floor division of the signed accumulator by 2^shift, then clamp.
   function automatic logic [16:0] ref_requant(input logic [31:0] d, input logic [4:0] sh);
      longint v, div, t;
      logic   sat;
      v   = longint'($signed(d));
      div = longint'(1) << sh;
`ifdef REQUANT_ROUND_EN
      if (sh != 0) v = v + div / 2;
`endif
      if (v >= 0) t = v / div;
      else        t = -((-v + div - 1) / div);
      sat = 1'b0;
      if (t > 32767) begin
         t = 32767; sat = 1'b1;
      end else if (t < -32768) begin
         t = -32768; sat = 1'b1;
      end
      return {sat, t[15:0]};
   endfunction

   // Check every output against the model, take one clock, advance the model.
   task automatic cycle();
      logic        exp_pop, exp_ready;
      logic [16:0] r;
      #1;
      exp_pop   = (q.size() > 0) && out_ready;
      exp_ready = (q.size() < DEPTH) || exp_pop;
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
         chk("out_data", out_data, q[0].data);
         chk("out_x", out_x, q[0].x);
         chk("out_y", out_y, q[0].y);
         chk("out_ch", out_ch, q[0].ch);
         chk("out_saturated", out_saturated, q[0].sat);
      end
      chk("overflow", overflow, ovf_m);
      chk("sat_count", sat_count, 64'(satc_m));
      @(posedge clk);
      if (exp_pop) begin
         $display("drain x=%0d y=%0d ch=%0d data=%h sat=%0b", q[0].x, q[0].y, q[0].ch, q[0].data, q[0].sat);
         void'(q.pop_front());
      end
      r = ref_requant(in_data, shift);
      if (clear) begin
         ovf_m  = 1'b0;
         satc_m = 0;
      end else begin
         if (in_valid && !exp_ready) ovf_m = 1'b1;
         if (in_valid && exp_ready && r[16] && satc_m < 65535) satc_m++;
      end
      if (in_valid && exp_ready) q.push_back('{r[15:0], in_x, in_y, in_ch, r[16]});
      #1;
   endtask

   task automatic do_reset();
      arst_n_in = 1'b0;
      #1;
      q.delete();
      ovf_m  = 1'b0;
      satc_m = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_saturated", out_saturated, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_sat_count", sat_count, 0);
      @(posedge clk);
      @(negedge clk);
      arst_n_in = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] d, input logic [4:0] sh, input logic [9:0] x);
      in_valid = 1'b1;
      in_data  = d;
      shift    = sh;
      in_x     = x;
      in_y     = x + 10'd100;
      in_ch    = x[5:0];
      cycle();
      in_valid = 1'b0;
   endtask

   vec_t tbl[11];

   initial begin
      arst_n_in = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_x      = '0;
      in_y      = '0;
      in_ch     = '0;
      shift     = '0;
      clear     = 1'b0;
      out_ready = 1'b0;
      do_reset();

`ifdef REQUANT_ROUND_EN
      tbl[0]  = '{32'h0000_1234, 5'd4,  16'h0123, 1'b0};
      tbl[3]  = '{32'h0000_0007, 5'd1,  16'h0004, 1'b0};
      tbl[4]  = '{32'hFFFF_FFF9, 5'd1,  16'hFFFD, 1'b0};
      tbl[5]  = '{32'h7FFF_FFFF, 5'd31, 16'h0001, 1'b0};
`else
      tbl[0]  = '{32'h0000_1234, 5'd4,  16'h0123, 1'b0};
      tbl[3]  = '{32'h0000_0007, 5'd1,  16'h0003, 1'b0};
      tbl[4]  = '{32'hFFFF_FFF9, 5'd1,  16'hFFFC, 1'b0};
      tbl[5]  = '{32'h7FFF_FFFF, 5'd31, 16'h0000, 1'b0};
`endif
      tbl[1]  = '{32'h0010_0000, 5'd0,  16'h7FFF, 1'b1};
      tbl[2]  = '{32'hFFF0_0000, 5'd0,  16'h8000, 1'b1};
      tbl[6]  = '{32'h8000_0000, 5'd31, 16'hFFFF, 1'b0};
      tbl[7]  = '{32'h0000_7FFF, 5'd0,  16'h7FFF, 1'b0};
      tbl[8]  = '{32'hFFFF_8000, 5'd0,  16'h8000, 1'b0};
      tbl[9]  = '{32'h0000_8000, 5'd0,  16'h7FFF, 1'b1};
      tbl[10] = '{32'h0001_0000, 5'd1,  16'h7FFF, 1'b1};

      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         push_one(tbl[i].d, tbl[i].sh, 10'(i * 3));
         chk("tbl_valid", out_valid, 1);
         chk("tbl_data", out_data, tbl[i].exp_data);
         chk("tbl_sat", out_saturated, tbl[i].exp_sat);
         chk("tbl_x", out_x, 64'(i * 3));
         cycle();
      end
      chk("tbl_sat_count", sat_count, 4);

      clear = 1'b1;
      cycle();
      clear = 1'b0;
      chk("clear_sat_count", sat_count, 0);

      // Backpressure: five pushes into a four-deep FIFO, the fifth is dropped.
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         in_valid = 1'b1;
         in_data  = 32'(k) << 4;
         shift    = 5'd4;
         in_x     = 10'(k);
         in_y     = 10'(k);
         in_ch    = 6'(k);
         cycle();
         if (k == 4) chk("full_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      chk("overflow_set", overflow, 1);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         #1;
         chk("drain_order_x", out_x, 64'(k));
         chk("drain_order_data", out_data, 64'(k));
         cycle();
      end
      chk("drained_empty", out_valid, 0);
      chk("overflow_sticky", overflow, 1);

      clear = 1'b1;
      cycle();
      clear = 1'b0;
      chk("clear_overflow", overflow, 0);

      // Full FIFO with simultaneous push and pop.
      out_ready = 1'b0;
      for (int k = 1; k <= 4; k++) push_one(32'(k + 10), 5'd0, 10'(k + 10));
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'd15;
      shift     = 5'd0;
      in_x      = 10'd15;
      #1;
      chk("full_pushpop_ready", in_ready, 1);
      cycle();
      in_valid = 1'b0;
      chk("full_pushpop_no_ovf", overflow, 0);
      for (int k = 12; k <= 15; k++) begin
         #1;
         chk("pushpop_order_x", out_x, 64'(k));
         cycle();
      end
      chk("pushpop_empty", out_valid, 0);

      // Reset in the middle of a drain with three entries buffered.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) push_one(32'(k + 20), 5'd0, 10'(k + 20));
      out_ready = 1'b1;
      cycle();
      #2;
      do_reset();
      chk("post_reset_empty", out_valid, 0);
      cycle();
      cycle();

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         clear     = ($urandom_range(0, 31) == 0);
         case ($urandom_range(0, 2))
            0:       in_data = $urandom;
            1:       in_data = 32'($signed(17'($urandom_range(0, 131071))));
            default: in_data = {{16{1'b0}}, 16'($urandom)} - 32'h0000_8000;
         endcase
         shift = 5'($urandom_range(0, 31));
         in_x  = 10'($urandom);
         in_y  = 10'($urandom);
         in_ch = 6'($urandom);
         cycle();
      end
      in_valid  = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 6; n++) cycle();
      chk("final_empty", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
